// File: rtl/feature_deserializer_if.sv
// Bus between the ui_in byte stream source and the feature deserializer.
// master drives the stream and ready; slave is the deserializer.
interface feature_deserializer_if #(
   parameter int N_WORDS = 5,
   parameter int W_DATA  = 5,
   parameter int W_POS   = 3
);
   logic                        ena;
   logic [W_DATA+W_POS-1:0]     ui_in;
   logic                        feat_ready;
   logic [N_WORDS*W_DATA-1:0]   feat_vec;
   logic                        feat_valid;
   logic                        seq_err;
   logic [7:0]                  frame_cnt;
   logic [W_POS-1:0]            word_idx;

   modport master (
      output ena, ui_in, feat_ready,
      input  feat_vec, feat_valid, seq_err, frame_cnt, word_idx
   );

   modport slave (
      input  ena, ui_in, feat_ready,
      output feat_vec, feat_valid, seq_err, frame_cnt, word_idx
   );
endinterface

// File: rtl/feature_deserializer.sv
// Collects tagged, bit-reversed feature words into a packed vector with valid/ready.
// FEAT_SEQ_CHECK_EN: strict in-order capture with sticky seq_err; otherwise any-order fill mask.
module feat_slot #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         we,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (we) q <= d;
   end
endmodule

module feature_deserializer #(
   parameter int N_WORDS = 5,
   parameter int W_DATA  = 5,
   parameter int W_POS   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   feature_deserializer_if.slave bus
);
   localparam logic [W_POS-1:0] LAST = W_POS'(N_WORDS-1);

   typedef enum logic {COLLECT, VALID} state_t;

   state_t                          state, state_n;
   logic [W_POS-1:0]                pos, exp_idx, last_pos, last_pos_n;
   logic [W_DATA-1:0]               word;
   logic [N_WORDS-1:0]              slot_we, pos_hot;
   logic [N_WORDS-1:0][W_DATA-1:0]  slot_q;
   logic [7:0]                      frame_cnt;
   logic                            hs;

   assign pos = bus.ui_in[W_POS-1:0];
   assign hs  = (state == VALID) && bus.feat_ready;

   // Word arrives MSB-first on the upper bits; undo the reversal.
   always_comb begin
      word = '0;
      for (int i = 0; i < W_DATA; i++) word[i] = bus.ui_in[W_DATA+W_POS-1-i];
   end

   always_comb begin
      pos_hot = '0;
      for (int k = 0; k < N_WORDS; k++) pos_hot[k] = (pos == W_POS'(k));
   end

   for (genvar k = 0; k < N_WORDS; k++) begin : g_slot
      feat_slot #(.W(W_DATA)) u_slot (
         .clk (clk),
         .rst_n (rst_n),
         .we  (slot_we[k]),
         .d   (word),
         .q   (slot_q[k])
      );
   end

`ifdef FEAT_SEQ_CHECK_EN
   logic [W_POS-1:0] exp_idx_n;
   logic             seq_err_q, seq_err_n;

   always_comb begin
      state_n    = state;
      exp_idx_n  = exp_idx;
      last_pos_n = last_pos;
      seq_err_n  = seq_err_q;
      slot_we    = '0;
      case (state)
         COLLECT: if (bus.ena) begin
            if (pos == last_pos) begin
               // repeat of the previous word, or the stale final word
            end else if (pos == exp_idx) begin
               slot_we    = pos_hot;
               last_pos_n = pos;
               exp_idx_n  = exp_idx + 1'b1;
               if (pos == LAST) state_n = VALID;
            end else begin
               seq_err_n  = 1'b1;
               exp_idx_n  = '0;
               last_pos_n = LAST;
            end
         end
         VALID: if (bus.feat_ready) begin
            state_n   = COLLECT;
            exp_idx_n = '0;
         end
         default: state_n = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_idx   <= '0;
         seq_err_q <= 1'b0;
      end else begin
         exp_idx   <= exp_idx_n;
         seq_err_q <= seq_err_n;
      end
   end

   assign bus.seq_err = seq_err_q;
`else
   logic [N_WORDS-1:0] fill, fill_n;

   always_comb begin
      state_n    = state;
      last_pos_n = last_pos;
      fill_n     = fill;
      slot_we    = '0;
      case (state)
         COLLECT: if (bus.ena && pos != last_pos && |pos_hot) begin
            slot_we    = pos_hot;
            fill_n     = fill | pos_hot;
            last_pos_n = pos;
            if (&fill_n) state_n = VALID;
         end
         VALID: if (bus.feat_ready) begin
            state_n = COLLECT;
            fill_n  = '0;
         end
         default: state_n = COLLECT;
      endcase
   end

   // Debug index reports the lowest slot still missing.
   always_comb begin
      exp_idx = '0;
      for (int k = N_WORDS-1; k >= 0; k--) if (!fill[k]) exp_idx = W_POS'(k);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fill <= '0;
      else        fill <= fill_n;
   end

   assign bus.seq_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         last_pos  <= LAST;
         frame_cnt <= '0;
      end else begin
         state    <= state_n;
         last_pos <= last_pos_n;
         if (hs && frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign bus.feat_vec   = slot_q;
   assign bus.feat_valid = (state == VALID);
   assign bus.frame_cnt  = frame_cnt;
   assign bus.word_idx   = (state == VALID) ? '0 : exp_idx;
endmodule

// File: tb/tb_feature_deserializer.sv
// Directed bench for feature_deserializer: expected vectors queued at stimulus time,
// compared by a monitor at every handshake.
module tb_feature_deserializer;
   typedef struct {
      logic [24:0] vec;
      logic        err;
   } exp_t;

   localparam logic [24:0] VEC_A = 25'b00001_00000_11111_10000_10110;
   localparam logic [24:0] VEC_B = 25'b00001_00001_00001_00001_00001;
   localparam logic [24:0] VEC_C = 25'b11111_11111_11111_11111_11111;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   exp_t mon_e;

   logic [7:0] fa[5] = '{8'h68, 8'h09, 8'hFA, 8'h03, 8'h84};
   logic [7:0] fb[5] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84};
   logic [7:0] fc[5] = '{8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC};

   always #5 clk = ~clk;

   feature_deserializer_if #(.N_WORDS(5), .W_DATA(5), .W_POS(3)) bus ();

   feature_deserializer #(.N_WORDS(5), .W_DATA(5), .W_POS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic e, input logic [7:0] u, input logic r);
      bus.ena        = e;
      bus.ui_in      = u;
      bus.feat_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_vec"},   32'(bus.feat_vec),   32'h0);
      chk({tag, "_valid"}, 32'(bus.feat_valid), 32'h0);
      chk({tag, "_err"},   32'(bus.seq_err),    32'h0);
      chk({tag, "_cnt"},   32'(bus.frame_cnt),  32'h0);
      chk({tag, "_idx"},   32'(bus.word_idx),   32'h0);
   endtask

   // Monitor: every accepted vector must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && bus.feat_valid && bus.feat_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL hs_unexpected actual_vec=%0h expected=none", bus.feat_vec);
         end else begin
            mon_e = sb.pop_front();
            if (bus.feat_vec !== mon_e.vec || bus.seq_err !== mon_e.err) begin
               bad++;
               $display("FAIL hs_vec actual=%0h/%0b expected=%0h/%0b",
                        bus.feat_vec, bus.seq_err, mon_e.vec, mon_e.err);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      bus.ena = 1'b0; bus.ui_in = 8'h00; bus.feat_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      // in-order frame, ready already high
      sb.push_back('{vec: VEC_A, err: 1'b0});
      for (int i = 0; i < 5; i++) begin
         step(1'b1, fa[i], 1'b1);
         if (i == 3) chk("valid_early", 32'(bus.feat_valid), 32'd0);
      end
      chk("valid_rise", 32'(bus.feat_valid), 32'd1);
      chk("idx_in_valid", 32'(bus.word_idx), 32'd0);
      step(1'b1, 8'h84, 1'b1);
      chk("valid_fall", 32'(bus.feat_valid), 32'd0);
      chk("cnt_1", 32'(bus.frame_cnt), 32'd1);
      chk("vec_kept", 32'(bus.feat_vec), 32'(VEC_A));

      // backpressure with the final word held
      sb.push_back('{vec: VEC_A, err: 1'b0});
      for (int i = 0; i < 5; i++) step(1'b1, fa[i], 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(bus.feat_valid), 32'd1);
         chk("bp_vec", 32'(bus.feat_vec), 32'(VEC_A));
         step(1'b1, 8'h84, 1'b0);
      end
      step(1'b1, 8'h84, 1'b1);
      chk("bp_fall", 32'(bus.feat_valid), 32'd0);
      chk("bp_idx", 32'(bus.word_idx), 32'd0);
      chk("cnt_2", 32'(bus.frame_cnt), 32'd2);
      step(1'b1, 8'h84, 1'b1);
      step(1'b1, 8'h84, 1'b1);
      chk("stale_valid", 32'(bus.feat_valid), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b1, fb[i], 1'b1);
      chk("stale_no_capture", 32'(bus.feat_valid), 32'd0);
      chk("idx_4", 32'(bus.word_idx), 32'd4);
      sb.push_back('{vec: VEC_B, err: 1'b0});
      step(1'b1, fb[4], 1'b1);
      chk("b_valid", 32'(bus.feat_valid), 32'd1);
      step(1'b1, fb[4], 1'b1);

      // each word held three cycles
      sb.push_back('{vec: VEC_C, err: 1'b0});
      for (int i = 0; i < 5; i++) repeat (3) step(1'b1, fc[i], 1'b1);
      chk("held_err", 32'(bus.seq_err), 32'd0);
      chk("cnt_4", 32'(bus.frame_cnt), 32'd4);

`ifdef FEAT_SEQ_CHECK_EN
      step(1'b1, 8'h68, 1'b1);
      step(1'b1, 8'hFA, 1'b1);
      chk("ooo_err", 32'(bus.seq_err), 32'd1);
      chk("ooo_idx", 32'(bus.word_idx), 32'd0);
      sb.push_back('{vec: VEC_A, err: 1'b1});
      for (int i = 0; i < 5; i++) step(1'b1, fa[i], 1'b1);
      chk("ooo_valid", 32'(bus.feat_valid), 32'd1);
      step(1'b1, 8'h84, 1'b1);
      chk("ooo_sticky", 32'(bus.seq_err), 32'd1);
`else
      sb.push_back('{vec: VEC_A, err: 1'b0});
      step(1'b1, fa[3], 1'b1);
      step(1'b1, fa[0], 1'b1);
      step(1'b1, fa[4], 1'b1);
      step(1'b1, fa[1], 1'b1);
      chk("perm_valid_early", 32'(bus.feat_valid), 32'd0);
      chk("perm_idx", 32'(bus.word_idx), 32'd2);
      step(1'b1, fa[2], 1'b1);
      chk("perm_valid", 32'(bus.feat_valid), 32'd1);
      step(1'b1, fa[2], 1'b1);
      chk("perm_err", 32'(bus.seq_err), 32'd0);
`endif
      chk("cnt_5", 32'(bus.frame_cnt), 32'd5);

      // reset mid-frame
      for (int i = 0; i < 3; i++) step(1'b1, fb[i], 1'b1);
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // enable gating on pos 2
      sb.push_back('{vec: VEC_B, err: 1'b0});
      step(1'b1, fb[0], 1'b1);
      step(1'b1, fb[1], 1'b1);
      repeat (3) step(1'b0, fb[2], 1'b1);
      chk("ena_stall_valid", 32'(bus.feat_valid), 32'd0);
      chk("ena_stall_idx", 32'(bus.word_idx), 32'd2);
      for (int i = 2; i < 5; i++) step(1'b1, fb[i], 1'b1);
      chk("ena_valid", 32'(bus.feat_valid), 32'd1);
      step(1'b1, fb[4], 1'b1);
      chk("ena_cnt", 32'(bus.frame_cnt), 32'd1);

      // frame counter saturation
      for (int f = 0; f < 300; f++) begin
         sb.push_back('{vec: (f % 2 == 1) ? VEC_C : VEC_B, err: 1'b0});
         for (int i = 0; i < 5; i++) step(1'b1, (f % 2 == 1) ? fc[i] : fb[i], 1'b1);
         step(1'b1, (f % 2 == 1) ? fc[4] : fb[4], 1'b1);
         if (f == 252) chk("cnt_254", 32'(bus.frame_cnt), 32'd254);
      end
      chk("cnt_sat", 32'(bus.frame_cnt), 32'd255);

      repeat (2) step(1'b0, 8'h00, 1'b0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
